// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per RUN cycle ripple through a chain
// of full-adder cells; result and flags are registered as the operation completes.

module serial_addsub_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic sum,
   output logic co
);
   assign sum = x ^ y ^ ci;
   assign co  = (x & y) | (ci & (x ^ y));
endmodule

module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             CF,
   output logic             OF,
   output logic             ZF
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of DIGIT");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept, last;
   logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nxt;
   logic             c, sub_r;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   cy;
   logic [DIGIT-1:0] dsum;

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (state == RUN) && (cnt == CW'(N - 1));

   // One digit of ripple; cy[DIGIT-1] is the carry into the MSB cell on the last digit.
   assign cy[0] = c;
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      serial_addsub_fa u_fa (
         .x  (a_sr[i]),
         .y  (b_sr[i]),
         .ci (cy[i]),
         .sum(dsum[i]),
         .co (cy[i+1])
      );
   end

   always_comb begin
      acc_nxt = acc;
      acc_nxt[int'(cnt) * DIGIT +: DIGIT] = dsum;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         c     <= 1'b0;
         sub_r <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         s     <= '0;
         CF    <= 1'b0;
         OF    <= 1'b0;
         ZF    <= 1'b0;
      end else if (accept) begin
         // Subtract is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
         a_sr  <= a;
         b_sr  <= sub ? ~b : b;
         c     <= sub ? ~cin : cin;
         sub_r <= sub;
         cnt   <= '0;
         acc   <= '0;
      end else if (state == RUN) begin
         a_sr <= a_sr >> DIGIT;
         b_sr <= b_sr >> DIGIT;
         c    <= cy[DIGIT];
         cnt  <= cnt + 1'b1;
         acc  <= acc_nxt;
         if (last) begin
            s  <= acc_nxt;
            CF <= sub_r ^ cy[DIGIT];
            OF <= cy[DIGIT] ^ cy[DIGIT-1];
            ZF <= (acc_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three configurations (8/1, 8/2, 16/4) driven with
// directed and random operations, checked against an integer-arithmetic model.

module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  st;
   logic        sub, cin;
   logic [15:0] a, b;
   logic [2:0]  busy_o, done_o, cf_o, of_o, zf_o;
   logic [7:0]  s0, s1;
   logic [15:0] s2;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d0 (
      .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
      .busy(busy_o[0]), .done(done_o[0]), .s(s0), .CF(cf_o[0]), .OF(of_o[0]), .ZF(zf_o[0]));

   serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d1 (
      .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
      .busy(busy_o[1]), .done(done_o[1]), .s(s1), .CF(cf_o[1]), .OF(of_o[1]), .ZF(zf_o[1]));

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d2 (
      .clk(clk), .rst(rst), .start(st[2]), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_o[2]), .done(done_o[2]), .s(s2), .CF(cf_o[2]), .OF(of_o[2]), .ZF(zf_o[2]));

   function automatic logic [15:0] sget(input int sel);
      return (sel == 0) ? {8'h00, s0} : (sel == 1) ? {8'h00, s1} : s2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
   task automatic model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts, output logic [15:0] es,
                        output logic ecf, output logic eof, output logic ezf);
      longint m, ua, ub, sa, sb, r, sr;
      m  = longint'(1) << w;
      ua = longint'(ta) & (m - 1);
      ub = longint'(tb) & (m - 1);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (!ts) begin
         r   = ua + ub + longint'(tc);
         sr  = sa + sb + longint'(tc);
         ecf = (r >= m);
      end else begin
         r   = ua - ub - longint'(tc);
         sr  = sa - sb - longint'(tc);
         ecf = (r < 0);
      end
      es  = 16'(r & (m - 1));
      eof = (sr < -(m / 2)) || (sr > m / 2 - 1);
      ezf = ((r & (m - 1)) == 0);
   endtask

   // Called just after a rising edge with the selected unit in IDLE or DONE.
   task automatic do_op(input int sel, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts, input bit disturb);
      int w, n, lat, nb;
      logic [15:0] es;
      logic ecf, eof, ezf;
      w = (sel == 2) ? 16 : 8;
      n = w / ((sel == 0) ? 1 : (sel == 1) ? 2 : 4);
      model(w, ta, tb, tc, ts, es, ecf, eof, ezf);
      a = ta; b = tb; cin = tc; sub = ts; st[sel] = 1'b1;
      @(posedge clk); #1;
      st[sel] = 1'b0;
      lat = 0; nb = 0;
      while (done_o[sel] !== 1'b1 && lat < 40) begin
         if (busy_o[sel] === 1'b1) nb++;
         if (disturb && lat == 2) begin
            st[sel] = 1'b1; a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
         end
         if (disturb && lat == 4) st[sel] = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency_edges[u%0d]", sel), lat, n);
      chk($sformatf("busy_cycles[u%0d]", sel), nb, n);
      chk($sformatf("s[u%0d a=%h b=%h c=%0d sub=%0d]", sel, ta, tb, tc, ts), sget(sel), es);
      chk($sformatf("CF[u%0d a=%h b=%h]", sel, ta, tb), cf_o[sel], ecf);
      chk($sformatf("OF[u%0d a=%h b=%h]", sel, ta, tb), of_o[sel], eof);
      chk($sformatf("ZF[u%0d a=%h b=%h]", sel, ta, tb), zf_o[sel], ezf);
      if (disturb) begin
         @(posedge clk); #1;
         chk("ignored_start_done", done_o[sel], 1'b0);
         chk("ignored_start_busy", busy_o[sel], 1'b0);
      end
   endtask

   initial begin
      int cyc;
      bit seen, hold_ok;
      rst = 1'b1; st = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int u = 0; u < 3; u++) begin
         chk($sformatf("rst_busy[u%0d]", u), busy_o[u], 1'b0);
         chk($sformatf("rst_done[u%0d]", u), done_o[u], 1'b0);
         chk($sformatf("rst_s[u%0d]", u), sget(u), 16'h0);
         chk($sformatf("rst_flags[u%0d]", u), {cf_o[u], of_o[u], zf_o[u]}, 3'b000);
      end

      // Directed add and subtract cases, including signed overflow and zero result.
      do_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("t1_s_const", sget(0), 16'h0080);
      chk("t1_flags_const", {cf_o[0], of_o[0], zf_o[0]}, 3'b010);
      do_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("t2_flags_const", {cf_o[1], of_o[1], zf_o[1]}, 3'b101);
      do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
      chk("t3a_s_const", sget(0), 16'h00FE);
      do_op(0, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0);
      chk("t3b_flags_const", {cf_o[0], of_o[0]}, 2'b01);
      do_op(0, 16'h0010, 16'h0003, 1'b1, 1'b1, 1'b0);
      do_op(1, 16'h00A5, 16'h005A, 1'b1, 1'b0, 1'b0);

      // Start pulse and operand changes during RUN must be ignored.
      do_op(0, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b1);

      // Reset at RUN cycle 3 discards the operation.
      a = 16'h0012; b = 16'h0034; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
      @(posedge clk); #1 st[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("midrst_busy", busy_o[0], 1'b0);
      chk("midrst_done", done_o[0], 1'b0);
      chk("midrst_s", sget(0), 16'h0);
      chk("midrst_flags", {cf_o[0], of_o[0], zf_o[0]}, 3'b000);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done_o[0] !== 1'b0) seen = 1'b1;
      end
      chk("midrst_no_done", seen, 1'b0);

      // Back-to-back with start held high; new operands accepted in the DONE cycle.
      a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0; st[0] = 1'b1;
      cyc = 0;
      while (done_o[0] !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("b2b_first_lat", cyc, 9);
      chk("b2b_first_s", sget(0), 16'h0030);
      a = 16'h0001; b = 16'h0001;
      cyc = 0; hold_ok = 1'b1;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (done_o[0] !== 1'b1 && sget(0) !== 16'h0030) hold_ok = 1'b0;
      end while (done_o[0] !== 1'b1 && cyc < 40);
      chk("b2b_gap", cyc, 9);
      chk("b2b_hold", hold_ok, 1'b1);
      chk("b2b_second_s", sget(0), 16'h0002);
      st[0] = 1'b0;
      @(posedge clk); #1;

      // Random operations on the 16-bit, 4-bit-digit unit.
      for (int i = 0; i < 1000; i++)
         do_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised digit-serial adder/subtractor, the successor to the 1-bit serial adder. It processes DIGIT bits per clock through a ripple of DIGIT full-adder cells and accumulates the sum into a result register. Adds a subtract mode, a start/busy/done handshake, synchronous reset, correctly timed flags and a zero flag. It is a shared arithmetic unit for area-constrained datapaths, where multi-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥2.
DIGIT, 1, bits processed per RUN cycle; must divide WIDTH exactly. Elaboration fails otherwise.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when accepted (IDLE or DONE state)
sub  input  1  0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in); latched with operands
a  input  WIDTH  operand a, latched on accepted start
b  input  WIDTH  operand b, latched on accepted start
cin  input  1  carry/borrow in, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result and flags valid
s  output  WIDTH  result
CF  output  1  add: carry out; sub: borrow out (the inverse of the internal carry)
OF  output  1  two's-complement signed overflow
ZF  output  1  s == 0

Behaviour:
- Reset
  - rst high at a rising edge forces IDLE.
  - busy, done, s, CF, OF and ZF all go to 0.
  - rst takes priority over start and over any in-progress RUN. A partial result is discarded and no done pulse is produced.
- FSM: IDLE, RUN, DONE.
  - IDLE: if start, go to RUN. Else stay.
  - RUN: stay for exactly N = WIDTH/DIGIT cycles, counted by a digit counter 0..N-1. At count N-1, go to DONE.
  - DONE: lasts one cycle, with done=1. If start is high in this cycle, it is accepted and the next state is RUN. Otherwise the next state is IDLE.
- Start acceptance
  - start is accepted in IDLE or DONE only. start during RUN is ignored; it is not queued.
  - On acceptance:
    - Latch a and b' = sub ? ~b : b.
    - Latch the internal carry c = sub ? ~cin : cin.
    - Latch sub.
    - Clear the digit counter and the result accumulator.
  - Input changes after acceptance have no effect on the operation.
- Each RUN cycle:
  - The low DIGIT bits of the a and b' shift registers ripple through DIGIT full adders with carry-in c.
  - The DIGIT sum bits are written into the result accumulator at digit position count (bits count*DIGIT+DIGIT-1 .. count*DIGIT).
  - c is updated to the ripple carry-out.
  - The a and b' shift registers shift right by DIGIT, zero-filled.
- Flags are computed in the last RUN cycle and registered so they appear with done. With cN = the final carry-out and cM = the carry into the MSB cell:
  - CF = sub ? ~cN : cN.
  - OF = cN ^ cM.
  - ZF = (final s == 0).
- Latency: if start is accepted at edge E, done is high in the cycle after edge E+N, i.e. N+1 cycles after start. busy is high for exactly N cycles.
- Output stability:
  - s, CF, OF and ZF update only at the transition into DONE.
  - They hold until the next DONE or reset. They do not go to 0 during a following RUN.
- Back-to-back operation: start held high continuously gives one result every N+1 cycles.

Test Plan:
1. WIDTH=8, DIGIT=1. Reset, then start with a=0x7F, b=0x01, cin=0, sub=0 -> done exactly 9 cycles after start, s=0x80, CF=0, OF=1, ZF=0. busy is high for 8 cycles.
2. WIDTH=8, DIGIT=2. Start with a=0xFF, b=0x01, cin=0, sub=0 -> done 5 cycles after start, s=0x00, CF=1, OF=0, ZF=1.
3. Subtract case. Start with a=0x05, b=0x07, cin=0, sub=1 -> s=0xFE, CF=1 (borrow), OF=0. Repeat with a=0x80, b=0x01 -> s=0x7F, CF=0, OF=1.
4. Mid-operation events:
   - Pulse start again and change a/b during RUN -> both ignored; the result matches the originally latched operands.
   - Assert rst at RUN cycle 3 -> next cycle shows busy=0, done=0, s=0 and all flags 0, and no done pulse follows.
5. Back-to-back: hold start high with a=0x10, b=0x20, then switch the inputs to a=0x01, b=0x01 during the first DONE cycle -> done pulses N+1 cycles apart with s=0x30, then s=0x02. s holds 0x30 between the two pulses.
6. WIDTH=16, DIGIT=4. Random a, b, cin and sub against a reference model, for at least 1000 operations -> s, CF, OF and ZF all match, and every operation has a latency of 5 cycles.
